// File: rtl/fd_pkg.sv
// fd_pkg: shared types and constants for the fetch->decode pipeline register
package fd_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        REPLAY = 2'd3
    } fd_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } fd_entry_t;

    localparam fd_entry_t FD_KILL = '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/fd_skid_buf.sv
// fd_skid_buf: one-entry capture/hold/clear buffer for the instruction seen at stall entry
module fd_skid_buf
    import fd_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            cap,
    input  logic            clr,
    input  logic [XLEN-1:0] d_instr,
    input  logic [XLEN-1:0] d_pc,
    input  logic            d_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    // clear wins over capture; otherwise the entry holds until the next stall entry
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
        end else if (cap) begin
            instr <= d_instr;
            pc    <= d_pc;
            valid <= d_valid;
        end
    end

endmodule

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: fetch->decode pipeline register with stall hold, replay and flush kill (optional FD_PERF_CNT_EN counters)
module fd_pipe_reg
    import fd_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] f_pc,
    input  logic [XLEN-1:0] f_pc4,
    input  logic            f_valid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] RegFD_PC,
    output logic [XLEN-1:0] RegFD_PC4,
    output logic [XLEN-1:0] RegFD_instr,
    output logic            RegFD_valid,
    output logic [XLEN-1:0] Stallunit_inst,
    output logic [XLEN-1:0] StallUnit_PC,
    output logic            Forward_instr,
    output logic            forward_PC
`ifdef FD_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);

    fd_state_e       state, state_nxt;
    logic [XLEN-1:0] s0_pc, s0_pc4;
    logic            s0_valid;
    fd_entry_t       fd_q, fd_d;
    logic            cap, clr, fwd;
    logic [XLEN-1:0] sk_instr, sk_pc;
    logic            sk_valid;

    // next state, skid control and next RegFD contents; flush outranks stall
    always_comb begin
        state_nxt = flush ? FLUSH : stall ? STALL : (state == STALL) ? REPLAY : RUN;
        cap       = stall && !flush && (state != STALL);
        clr       = flush || ((state == STALL) && !stall);
        fd_d      = flush ? FD_KILL :
                    stall ? fd_q :
                    (state == STALL) ? fd_entry_t'{pc: sk_pc, pc4: s0_pc4, instr: sk_instr, valid: sk_valid} :
                    fd_entry_t'{pc: s0_pc, pc4: s0_pc4, instr: s0_valid ? imem_rdata : NOP_INSTR, valid: s0_valid};
    end

    // state register and registered replay select
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fwd   <= 1'b0;
        end else begin
            state <= state_nxt;
            fwd   <= (state_nxt == REPLAY);
        end
    end

    // align stage: PC of the imem read whose data arrives next cycle; a flush marks it wrong-path
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_pc    <= '0;
            s0_pc4   <= '0;
            s0_valid <= 1'b0;
        end else if (flush) begin
            s0_pc    <= f_pc;
            s0_pc4   <= f_pc4;
            s0_valid <= 1'b0;
        end else if (!stall) begin
            s0_pc    <= f_pc;
            s0_pc4   <= f_pc4;
            s0_valid <= f_valid;
        end
    end

    // RegFD stage
    always_ff @(posedge clk) begin
        if (rst) fd_q <= FD_KILL;
        else     fd_q <= fd_d;
    end

    fd_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .cap     (cap),
        .clr     (clr),
        .d_instr (s0_valid ? imem_rdata : NOP_INSTR),
        .d_pc    (s0_pc),
        .d_valid (s0_valid),
        .instr   (sk_instr),
        .pc      (sk_pc),
        .valid   (sk_valid)
    );

`ifdef FD_PERF_CNT_EN
    // stall cycles counted per cycle spent in STALL; flushes counted per accepted flush
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, state == STALL};
            flush_count  <= flush_count + {31'd0, flush};
        end
    end
`endif

    assign RegFD_PC       = fd_q.pc;
    assign RegFD_PC4      = fd_q.pc4;
    assign RegFD_instr    = fd_q.instr;
    assign RegFD_valid    = fd_q.valid;
    assign Stallunit_inst = sk_instr;
    assign StallUnit_PC   = sk_pc;
    assign Forward_instr  = fwd;
    assign forward_PC     = fwd;

endmodule
